cnn_bram_arbiter: RTL and testbench
===================================

CNN_BRAM_ARBITER -- requirements
Module: cnn_bram_arbiter

Interface
REQ-001 Parameter ADDR_W, default 16, BRAM address width.
REQ-002 Parameter DATA_W, default 8, BRAM data width.
REQ-003 Parameter RD_LAT, default 1, BRAM read latency in cycles (1..4).
REQ-004 Port clk, input, 1: single clock; all logic SHALL be on the rising edge.
REQ-005 Port rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 Ports wr_req, wr_addr, wr_data: input, 1/ADDR_W/DATA_W; write requester (feature-map loader).
REQ-007 Port wr_gnt, output, 1: write accepted this cycle.
REQ-008 Ports rd0_req, rd0_addr: input, 1/ADDR_W; read requester 0 (weight fetch).
REQ-009 Ports rd1_req, rd1_addr: input, 1/ADDR_W; read requester 1 (activation fetch).
REQ-010 Ports rd0_gnt, rd1_gnt: output, 1; read accepted this cycle.
REQ-011 Ports rd0_valid, rd0_data, rd1_valid, rd1_data: output, 1/DATA_W; returned read data.
REQ-012 Ports bram_en, bram_we, bram_addr, bram_din: output, 1/1/ADDR_W/DATA_W; registered single-port BRAM drive.
REQ-013 Port bram_dout, input, DATA_W: BRAM read data.

Function
REQ-014 Requests SHALL be level-held; a requester SHALL keep req, addr, data stable until its gnt is seen high.
REQ-015 At most one gnt SHALL be high per cycle; gnt is combinational from req and arbiter state.
REQ-016 Priority: write over reads; between rd0 and rd1, round-robin pointer rr (0 or 1) selects the favoured one.
REQ-017 rr SHALL toggle to the non-granted reader after each read grant; unchanged on write grant or idle.
REQ-018 A grant in cycle t SHALL drive bram_en=1, bram_we, bram_addr, bram_din in cycle t+1; otherwise bram_en=0, bram_we=0.
REQ-019 A read granted in cycle t SHALL produce rdX_valid=1 for exactly one cycle at t+1+RD_LAT, rdX_data=bram_dout that cycle.
REQ-020 Return routing SHALL use a RD_LAT+1-deep tag pipeline (valid bit + requester id); back-to-back reads every cycle SHALL be supported, full throughput.
REQ-021 Simultaneous rd0_req and rd1_req with no write: favoured reader granted; the other granted the next cycle if still requesting.
REQ-022 rdX_data SHALL hold its last value when rdX_valid=0.
REQ-023 No write-to-read forwarding; a read issued the cycle after a write to the same address returns BRAM behaviour (read-first per BRAM config).

Reset
REQ-024 rst_n low SHALL asynchronously clear: all gnt=0, bram_en=0, bram_we=0, bram_addr=0, bram_din=0, rd0/rd1_valid=0, rd0/rd1_data=0, rr=0, tag pipeline empty, starvation counter=0.
REQ-025 Reads in flight at reset SHALL be discarded; no rdX_valid after reset release for them.
REQ-026 Grants SHALL resume the first clk edge after rst_n deassertion.

Configuration
REQ-027 Macro CNN_ARB_STARVE_GUARD_EN defined: a 2-bit counter of consecutive write grants; when it reaches 3 and any read is pending, the next grant SHALL go to the reader (round-robin) instead of the writer, and the counter clears on any read grant.
REQ-028 Macro undefined: strict write priority, no counter logic synthesized.

Structure
REQ-029 Shared package cnn_bram_pkg SHALL hold ADDR_W/DATA_W defaults and the requester-id encoding (WR=0, RD0=1, RD1=2).
REQ-030 Return tag pipeline SHALL be sub-module cnn_bram_tag_pipe (parameter depth, id in, valid/id out).

Verification
REQ-031 Reset mid-stream: rd0 granted cycle 5, rst_n low cycle 6 -> no rd0_valid ever, all outputs 0 during reset.
REQ-032 Write addr 3 data 0x55 then rd0 addr 3 (RD_LAT=1) -> wr_gnt cycle t, rd0_gnt t+1, rd0_valid at t+3 with rd0_data=0x55.
REQ-033 rd0_req and rd1_req held high 8 cycles, no write -> gnts alternate rd0,rd1,rd0,...; 8 valids in order, correct data to each port.
REQ-034 wr_req held 10 cycles plus rd1_req held: guard off -> rd1_gnt only after wr_req drops; guard on -> rd1_gnt on 4th cycle.
REQ-035 RD_LAT=3, back-to-back rd0 addrs 0..7 preloaded 0x10..0x17 -> 8 consecutive rd0_valid cycles, data 0x10..0x17, first at gnt+4.

Source files
------------

// File: rtl/cnn_bram_pkg.sv
// Shared defaults and requester-id encoding for the CNN BRAM arbiter slice.
package cnn_bram_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        ID_WR  = 2'd0,
        ID_RD0 = 2'd1,
        ID_RD1 = 2'd2
    } req_id_t;

endpackage

// File: rtl/cnn_bram_tag_pipe.sv
// Return-routing tag pipeline: carries a valid bit and requester id alongside
// the BRAM read latency so returned data can be steered to the right reader.
module cnn_bram_tag_pipe
    import cnn_bram_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    in_vld,
    input  req_id_t in_id,
    output logic    out_vld,
    output req_id_t out_id
);

    logic [DEPTH-1:0] vld_p;
    req_id_t          id_p [DEPTH];

    // Only the valid bits are cleared, which is enough to drop in-flight reads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p <= '0;
        end else begin
            vld_p <= {vld_p[DEPTH-2:0], in_vld};
        end
    end

    always_ff @(posedge clk) begin
        id_p[0] <= in_id;
        for (int i = 1; i < DEPTH; i++) begin
            id_p[i] <= id_p[i-1];
        end
    end

    assign out_vld = vld_p[DEPTH-1];
    assign out_id  = id_p[DEPTH-1];

endmodule

// File: rtl/cnn_bram_arbiter.sv
// Single-port BRAM arbiter: one writer over two round-robin readers.
// Define CNN_ARB_STARVE_GUARD_EN to let readers in after three consecutive write grants.
module cnn_bram_arbiter
    import cnn_bram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_gnt,
    input  logic              rd0_req,
    input  logic [ADDR_W-1:0] rd0_addr,
    input  logic              rd1_req,
    input  logic [ADDR_W-1:0] rd1_addr,
    output logic              rd0_gnt,
    output logic              rd1_gnt,
    output logic              rd0_valid,
    output logic [DATA_W-1:0] rd0_data,
    output logic              rd1_valid,
    output logic [DATA_W-1:0] rd1_data,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    input  logic [DATA_W-1:0] bram_dout
);

    logic              rr;
    logic              force_rd;
    logic              rd_gnt_any;
    logic              tag_vld;
    req_id_t           tag_id;
    logic [DATA_W-1:0] hold0;
    logic [DATA_W-1:0] hold1;

    assign rd_gnt_any = rd0_gnt | rd1_gnt;

`ifdef CNN_ARB_STARVE_GUARD_EN
    logic [1:0] wr_run;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_run <= 2'd0;
        end else if (rd_gnt_any) begin
            wr_run <= 2'd0;
        end else if (wr_gnt && (wr_run != 2'd3)) begin
            wr_run <= wr_run + 2'd1;
        end
    end

    assign force_rd = (wr_run == 2'd3) && (rd0_req || rd1_req);
`else
    assign force_rd = 1'b0;
`endif

    // Grants are combinational; rr=0 favours rd0, rr=1 favours rd1.
    always_comb begin
        wr_gnt  = 1'b0;
        rd0_gnt = 1'b0;
        rd1_gnt = 1'b0;
        if (rst_n) begin
            if (wr_req && !force_rd) begin
                wr_gnt = 1'b1;
            end else if (rd0_req && (!rr || !rd1_req)) begin
                rd0_gnt = 1'b1;
            end else if (rd1_req) begin
                rd1_gnt = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr <= 1'b0;
        end else if (rd0_gnt) begin
            rr <= 1'b1;
        end else if (rd1_gnt) begin
            rr <= 1'b0;
        end
    end

    // Stage boundary: grant cycle -> registered BRAM drive.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bram_en   <= 1'b0;
            bram_we   <= 1'b0;
            bram_addr <= '0;
            bram_din  <= '0;
        end else begin
            bram_en <= wr_gnt | rd_gnt_any;
            bram_we <= wr_gnt;
            if (wr_gnt) begin
                bram_addr <= wr_addr;
                bram_din  <= wr_data;
            end else if (rd0_gnt) begin
                bram_addr <= rd0_addr;
            end else if (rd1_gnt) begin
                bram_addr <= rd1_addr;
            end
        end
    end

    cnn_bram_tag_pipe #(
        .DEPTH (RD_LAT + 1)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .in_vld  (rd_gnt_any),
        .in_id   (rd0_gnt ? ID_RD0 : ID_RD1),
        .out_vld (tag_vld),
        .out_id  (tag_id)
    );

    // Stage boundary: BRAM output -> reader return ports.
    assign rd0_valid = tag_vld && (tag_id == ID_RD0);
    assign rd1_valid = tag_vld && (tag_id == ID_RD1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            if (rd0_valid) hold0 <= bram_dout;
            if (rd1_valid) hold1 <= bram_dout;
        end
    end

    assign rd0_data = rd0_valid ? bram_dout : hold0;
    assign rd1_data = rd1_valid ? bram_dout : hold1;

endmodule

// File: tb/tb_cnn_bram_arbiter.sv
// Randomized bench for cnn_bram_arbiter: two instances (RD_LAT=1 and RD_LAT=3)
// share stimulus and are checked every cycle against a transaction-level model.
`timescale 1ns/1ps
module tb_cnn_bram_arbiter;
    import cnn_bram_pkg::*;

    localparam int AW = 16;
    localparam int DW = 8;
`ifdef CNN_ARB_STARVE_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          wr_req = 1'b0, rd0_req = 1'b0, rd1_req = 1'b0;
    logic [AW-1:0] wr_addr = '0, rd0_addr = '0, rd1_addr = '0;
    logic [DW-1:0] wr_data = '0;

    logic          a_wr_gnt, a_rd0_gnt, a_rd1_gnt, a_rd0_valid, a_rd1_valid, a_en, a_we;
    logic [DW-1:0] a_rd0_data, a_rd1_data, a_din, a_dout;
    logic [AW-1:0] a_addr;
    logic          b_wr_gnt, b_rd0_gnt, b_rd1_gnt, b_rd0_valid, b_rd1_valid, b_en, b_we;
    logic [DW-1:0] b_rd0_data, b_rd1_data, b_din, b_dout;
    logic [AW-1:0] b_addr;

    cnn_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(a_wr_gnt),
        .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd1_req(rd1_req), .rd1_addr(rd1_addr),
        .rd0_gnt(a_rd0_gnt), .rd1_gnt(a_rd1_gnt),
        .rd0_valid(a_rd0_valid), .rd0_data(a_rd0_data), .rd1_valid(a_rd1_valid), .rd1_data(a_rd1_data),
        .bram_en(a_en), .bram_we(a_we), .bram_addr(a_addr), .bram_din(a_din), .bram_dout(a_dout)
    );

    cnn_bram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(3)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(b_wr_gnt),
        .rd0_req(rd0_req), .rd0_addr(rd0_addr), .rd1_req(rd1_req), .rd1_addr(rd1_addr),
        .rd0_gnt(b_rd0_gnt), .rd1_gnt(b_rd1_gnt),
        .rd0_valid(b_rd0_valid), .rd0_data(b_rd0_data), .rd1_valid(b_rd1_valid), .rd1_data(b_rd1_data),
        .bram_en(b_en), .bram_we(b_we), .bram_addr(b_addr), .bram_din(b_din), .bram_dout(b_dout)
    );

    // Read-first single-port BRAM models, preloaded with 0x10+addr.
    logic          mem_load = 1'b1;
    logic [DW-1:0] mem_a [16];
    logic [DW-1:0] mem_b [16];
    logic [DW-1:0] pa;
    logic [DW-1:0] pb [3];

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem_a[i] <= 8'(8'h10 + i);
        end else if (a_en) begin
            pa <= mem_a[a_addr[3:0]];
            if (a_we) mem_a[a_addr[3:0]] <= a_din;
        end
    end
    assign a_dout = pa;

    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 16; i++) mem_b[i] <= 8'(8'h10 + i);
        end else if (b_en) begin
            pb[0] <= mem_b[b_addr[3:0]];
            if (b_we) mem_b[b_addr[3:0]] <= b_din;
        end
        pb[1] <= pb[0];
        pb[2] <= pb[1];
    end
    assign b_dout = pb[2];

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model state
    typedef struct {
        int            id;
        logic [DW-1:0] data;
        int            due;
    } ret_t;

    ret_t          qa[$];
    ret_t          qb[$];
    logic [DW-1:0] refmem [16];
    logic          rr_m;
    int            cnt_m;
    logic          prev_en, prev_we;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_din;
    logic [DW-1:0] last_a0, last_a1, last_b0, last_b1;
    logic          g_w, g_0, g_1;

    // Stimulus controls
    logic rst_ctl = 1'b0;
    int   p_w = 0, p_0 = 0, p_1 = 0;
    bit   fix_wr = 0, fix_r0 = 0, seq_r0 = 0;
    int   seq_cnt = 0;

    task automatic model_reset();
        rr_m = 1'b0; cnt_m = 0;
        prev_en = 1'b0; prev_we = 1'b0; prev_addr = '0; prev_din = '0;
        qa.delete(); qb.delete();
        last_a0 = '0; last_a1 = '0; last_b0 = '0; last_b1 = '0;
        g_w = 1'b0; g_0 = 1'b0; g_1 = 1'b0;
    endtask

    task automatic check_cycle();
        logic          in_rst, e_w, e0, e1, force_rd;
        logic          v0, v1;
        logic [DW-1:0] d;
        ret_t          r;
        in_rst = !rst_n;
        if (in_rst) model_reset();

        e_w = 1'b0; e0 = 1'b0; e1 = 1'b0;
        if (!in_rst) begin
            force_rd = GUARD && (cnt_m == 3) && (rd0_req || rd1_req);
            if (wr_req && !force_rd)    e_w = 1'b1;
            else if (rd0_req && rd1_req) begin
                if (rr_m) e1 = 1'b1; else e0 = 1'b1;
            end
            else if (rd0_req)           e0 = 1'b1;
            else if (rd1_req)           e1 = 1'b1;
        end
        check_eq("gnt_lat1", {a_wr_gnt, a_rd0_gnt, a_rd1_gnt}, {e_w, e0, e1});
        check_eq("gnt_lat3", {b_wr_gnt, b_rd0_gnt, b_rd1_gnt}, {e_w, e0, e1});

        check_eq("bram_ctl_lat1", {a_en, a_we}, {prev_en, prev_we});
        check_eq("bram_addr_lat1", a_addr, prev_addr);
        check_eq("bram_din_lat1", a_din, prev_din);
        check_eq("bram_ctl_lat3", {b_en, b_we}, {prev_en, prev_we});
        check_eq("bram_addr_lat3", b_addr, prev_addr);

        v0 = 1'b0; v1 = 1'b0;
        if (qa.size() > 0 && qa[0].due == cyc) begin
            r = qa.pop_front();
            v0 = (r.id == 1); v1 = (r.id == 2);
            if (v0) last_a0 = r.data;
            if (v1) last_a1 = r.data;
        end
        check_eq("rd_valid_lat1", {a_rd0_valid, a_rd1_valid}, {v0, v1});
        check_eq("rd0_data_lat1", a_rd0_data, last_a0);
        check_eq("rd1_data_lat1", a_rd1_data, last_a1);

        v0 = 1'b0; v1 = 1'b0;
        if (qb.size() > 0 && qb[0].due == cyc) begin
            r = qb.pop_front();
            v0 = (r.id == 1); v1 = (r.id == 2);
            if (v0) last_b0 = r.data;
            if (v1) last_b1 = r.data;
        end
        check_eq("rd_valid_lat3", {b_rd0_valid, b_rd1_valid}, {v0, v1});
        check_eq("rd0_data_lat3", b_rd0_data, last_b0);
        check_eq("rd1_data_lat3", b_rd1_data, last_b1);

        if (!in_rst) begin
            if (prev_en && prev_we) refmem[prev_addr[3:0]] = prev_din;
            prev_en = e_w | e0 | e1;
            prev_we = e_w;
            if (e_w) begin
                prev_addr = wr_addr; prev_din = wr_data;
            end else if (e0) begin
                prev_addr = rd0_addr;
            end else if (e1) begin
                prev_addr = rd1_addr;
            end
            if (e0 || e1) begin
                d = refmem[prev_addr[3:0]];
                qa.push_back('{e0 ? 1 : 2, d, cyc + 2});
                qb.push_back('{e0 ? 1 : 2, d, cyc + 4});
                rr_m  = e0;
                cnt_m = 0;
            end else if (e_w && cnt_m < 3) begin
                cnt_m++;
            end
        end
        g_w = e_w; g_0 = e0; g_1 = e1;
    endtask

    task automatic one_cycle();
        @(posedge clk);
        #1;
        rst_n = rst_ctl;
        if (wr_req && g_w)  wr_req = 1'b0;
        if (rd0_req && g_0) rd0_req = 1'b0;
        if (rd1_req && g_1) rd1_req = 1'b0;
        if (!wr_req && ($urandom_range(99) < p_w)) begin
            wr_req  = 1'b1;
            wr_addr = fix_wr ? 16'd3 : 16'($urandom_range(15));
            wr_data = fix_wr ? 8'h55 : 8'($urandom);
        end
        if (!rd0_req && ($urandom_range(99) < p_0)) begin
            rd0_req = 1'b1;
            if (seq_r0) begin
                rd0_addr = 16'(seq_cnt);
                seq_cnt++;
            end else begin
                rd0_addr = fix_r0 ? 16'd3 : 16'($urandom_range(15));
            end
        end
        if (!rd1_req && ($urandom_range(99) < p_1)) begin
            rd1_req  = 1'b1;
            rd1_addr = 16'($urandom_range(15));
        end
        @(negedge clk);
        cyc++;
        check_cycle();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) one_cycle();
    endtask

    initial begin
        int first_r1;
        for (int i = 0; i < 16; i++) refmem[i] = 8'(8'h10 + i);
        model_reset();

        // Power-on reset with requests pending: every output must stay low.
        rst_ctl = 1'b0; p_0 = 100; p_1 = 100;
        run(3);
        mem_load = 1'b0; p_0 = 0; p_1 = 0;
        rd0_req = 1'b0; rd1_req = 1'b0;
        rst_ctl = 1'b1;
        run(2);

        // Back-to-back rd0 over preloaded addresses 0..7.
        seq_r0 = 1; p_0 = 100;
        run(8);
        seq_r0 = 0; p_0 = 0;
        run(8);

        // Both readers held: grants alternate.
        p_0 = 100; p_1 = 100;
        run(8);
        p_0 = 0; p_1 = 0;
        run(8);

        // Write 0x55 to address 3, then read it back through rd0.
        fix_wr = 1; p_w = 100;
        run(1);
        p_w = 0; fix_wr = 0; fix_r0 = 1; p_0 = 100;
        run(1);
        p_0 = 0; fix_r0 = 0;
        run(6);

        // Writer held 10 cycles against a waiting rd1.
        first_r1 = -1;
        p_1 = 100;
        for (int k = 1; k <= 14; k++) begin
            p_w = (k <= 10) ? 100 : 0;
            one_cycle();
            if (a_rd1_gnt && first_r1 < 0) first_r1 = k;
        end
        check_eq("starve_first_rd1", first_r1, GUARD ? 4 : 11);
        p_w = 0; p_1 = 0;
        run(6);

        // Reset while a read is in flight: it must never return.
        p_0 = 100;
        run(1);
        p_0 = 0; rst_ctl = 1'b0;
        run(3);
        rst_ctl = 1'b1;
        run(8);

        // Random mixed traffic with one reset in the middle.
        for (int blk = 0; blk < 8; blk++) begin
            p_w = $urandom_range(60);
            p_0 = $urandom_range(20, 90);
            p_1 = $urandom_range(20, 90);
            run(50);
            if (blk == 4) begin
                rst_ctl = 1'b0;
                run(2);
                rst_ctl = 1'b1;
            end
        end
        p_w = 0; p_0 = 0; p_1 = 0;
        run(10);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
